// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmit port between N_REQ byte streams.
// An owner keeps the port until its last byte is written or its idle watchdog expires.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DBIT-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    tx_full,
    output logic                    wr_uart,
    output logic [DBIT-1:0]         w_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [PW-1:0]   owner, owner_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            timeout_n;

    logic            own_valid;
    logic            own_last;
    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   nxt;

    assign own_valid = |(req_valid & grant);
    assign own_last  = |(req_last & grant);
    assign req_ready = tx_full ? '0 : grant;
    assign wr_uart   = own_valid & ~tx_full;
    assign busy      = (state == XFER);
    assign nxt       = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) w_data = w_data | req_data[i*DBIT +: DBIT];
        end
    end

    // first valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        owner_n   = owner;
        ptr_n     = ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n      = XFER;
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    owner_n      = sel;
                    cnt_n        = '0;
                end
            end
            XFER: begin
                if (own_valid && !tx_full) begin
                    cnt_n = '0;
                    if (own_last) begin
                        state_n = IDLE;
                        grant_n = '0;
                        ptr_n   = nxt;
                    end
                end else if (!own_valid) begin
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        state_n   = IDLE;
                        grant_n   = '0;
                        ptr_n     = nxt;
                        cnt_n     = '0;
                        timeout_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand sequences
// for stall, watchdog release and mid-packet reset.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    logic       cap_en = 1'b0;
    logic [7:0] cap_q[$];

    uart_tx_arbiter #(.N_REQ(4), .DBIT(8), .TIMEOUT(64)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_full(tx_full),
        .wr_uart(wr_uart),
        .w_data(w_data),
        .grant(grant),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cap_en && wr_uart) cap_q.push_back(w_data);
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        full;
        logic [31:0] d;
        logic [3:0]  g;
        logic        wr;
        logic [3:0]  rdy;
        logic [7:0]  wd;
        logic        bz;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l,
                                logic [31:0] d, logic [3:0] g, logic [7:0] wd);
        vec_t r;
        r.rst  = rst;
        r.v    = v;
        r.l    = l;
        r.full = 1'b0;
        r.d    = d;
        r.g    = g;
        r.wr   = (g != 4'b0);
        r.rdy  = g;
        r.wd   = wd;
        r.bz   = (g != 4'b0);
        r.to   = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic full, input logic [31:0] d);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        tx_full   = full;
        req_data  = d;
        #1;
    endtask

    initial begin
        // single 3-byte packet from req0
        tbl.push_back(mk(0, 4'h1, 4'h0, 32'h41, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h0, 32'h41, 4'h1, 8'h41));
        tbl.push_back(mk(0, 4'h1, 4'h0, 32'h42, 4'h1, 8'h42));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h43, 4'h1, 8'h43));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h00, 4'h0, 8'h00));
        // req0 and req2 contend after reset
        tbl.push_back(mk(1, 4'h0, 4'h0, 32'h00, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h0, 32'h00300010, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h0, 32'h00300010, 4'h1, 8'h10));
        tbl.push_back(mk(0, 4'h5, 4'h1, 32'h00300011, 4'h1, 8'h11));
        tbl.push_back(mk(0, 4'h5, 4'h5, 32'h00300012, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h5, 32'h00300012, 4'h4, 8'h30));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h00000012, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h00000012, 4'h1, 8'h12));
        // all four valid, single-byte packets rotate 0,1,2,3,0
        tbl.push_back(mk(1, 4'h0, 4'h0, 32'h00, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h1, 8'hD0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h2, 8'hD1));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h4, 8'hD2));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h8, 8'hD3));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hD3D2D1D0, 4'h1, 8'hD0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h00, 4'h0, 8'h00));

        #1;
        chk("reset grant", 32'(grant), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset wr_uart", 32'(wr_uart), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            tx_full   = tbl[i].full;
            req_data  = tbl[i].d;
            #1;
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("row%0d wr_uart", i), 32'(wr_uart), 32'(tbl[i].wr));
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d w_data", i), 32'(w_data), 32'(tbl[i].wd));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("row%0d timeout", i), 32'(timeout), 32'(tbl[i].to));
        end

        // tx_full stall mid-packet from req1 (ptr is 1 here)
        cap_q.delete();
        cap_en = 1'b1;
        drive(4'h2, 4'h0, 1'b0, 32'h0000A000);
        chk("stall idle grant", 32'(grant), 32'h0);
        drive(4'h2, 4'h0, 1'b0, 32'h0000A000);
        chk("stall first wr", 32'(wr_uart), 32'h1);
        for (int k = 0; k < 5; k++) begin
            drive(4'h2, 4'h0, 1'b1, 32'h0000A100);
            chk($sformatf("stall%0d wr_uart", k), 32'(wr_uart), 32'h0);
            chk($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'h0);
            chk($sformatf("stall%0d grant", k), 32'(grant), 32'h2);
            chk($sformatf("stall%0d timeout", k), 32'(timeout), 32'h0);
        end
        drive(4'h2, 4'h0, 1'b0, 32'h0000A100);
        chk("stall resume wr", 32'(wr_uart), 32'h1);
        chk("stall resume data", 32'(w_data), 32'hA1);
        drive(4'h2, 4'h2, 1'b0, 32'h0000A200);
        chk("stall last data", 32'(w_data), 32'hA2);
        drive(4'h0, 4'h0, 1'b0, 32'h0);
        chk("stall end grant", 32'(grant), 32'h0);
        cap_en = 1'b0;
        chk("stall byte count", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            chk("stall byte0", 32'(cap_q[0]), 32'hA0);
            chk("stall byte1", 32'(cap_q[1]), 32'hA1);
            chk("stall byte2", 32'(cap_q[2]), 32'hA2);
        end

        // watchdog: req2 sends one byte then goes silent (ptr is 2 here)
        drive(4'h4, 4'h0, 1'b0, 32'h00550000);
        drive(4'h4, 4'h0, 1'b0, 32'h00550000);
        chk("wd first wr", 32'(wr_uart), 32'h1);
        chk("wd first data", 32'(w_data), 32'h55);
        for (int k = 1; k <= 64; k++) begin
            drive(4'h8, 4'h8, 1'b0, 32'h77000000);
            chk($sformatf("wd idle%0d grant", k), 32'(grant), 32'h4);
            chk($sformatf("wd idle%0d timeout", k), 32'(timeout), 32'h0);
        end
        drive(4'h8, 4'h8, 1'b0, 32'h77000000);
        chk("wd release grant", 32'(grant), 32'h0);
        chk("wd pulse", 32'(timeout), 32'h1);
        chk("wd release busy", 32'(busy), 32'h0);
        drive(4'h8, 4'h8, 1'b0, 32'h77000000);
        chk("wd pulse end", 32'(timeout), 32'h0);
        chk("wd next grant", 32'(grant), 32'h8);
        chk("wd next data", 32'(w_data), 32'h77);
        drive(4'h0, 4'h0, 1'b0, 32'h0);

        // reset during XFER from req0 (ptr is 0 here)
        drive(4'h1, 4'h0, 1'b0, 32'h00000099);
        drive(4'h1, 4'h0, 1'b0, 32'h00000099);
        chk("rst pre grant", 32'(grant), 32'h1);
        @(negedge clk);
        req_data = 32'h0000009A;
        reset = 1'b1;
        #1;
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst wr_uart", 32'(wr_uart), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'h3;
        req_last = 4'h3;
        req_data = 32'h0000CCBB;
        #1;
        chk("rst idle grant", 32'(grant), 32'h0);
        drive(4'h3, 4'h3, 1'b0, 32'h0000CCBB);
        chk("rst ptr0 grant", 32'(grant), 32'h1);
        chk("rst ptr0 data", 32'(w_data), 32'hBB);
        drive(4'h0, 4'h0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
